// File: rtl/pattern_bank.sv
`default_nettype none
// ============================================================================
// Module      : pattern_bank
// Description : Parametrised pattern store for the PAT processor. DEPTH fields
//               of WIDTH bits, reachable through a bit-serial scan chain
//               (sin -> field 0 bit 0 ... field DEPTH-1 bit WIDTH-1 -> sout)
//               and through a binary-addressed write port plus a registered
//               (latency 1) read port. A frame counter pulses frame_done
//               after every DEPTH*WIDTH shifts. A write that collides with a
//               shift, or that addresses a non-existent field, is discarded
//               and reported on wr_drop one cycle later.
//               Optional macro PATBUF_RD2_EN adds an independent second read
//               port (rd2_addr / rd2_data).
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_bank #(
    parameter  int DEPTH = 22,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ssel,
    input  logic             sin,
    output logic             sout,
    input  logic             sclr,
    output logic             frame_done,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_drop,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
`ifdef PATBUF_RD2_EN
    ,
    input  logic [AW-1:0]    rd2_addr,
    output logic [WIDTH-1:0] rd2_data
`endif
);

    // Frame length in shifts and the counter sized to hold 0..C_FRAME_LEN-1
    localparam int              C_FRAME_LEN = DEPTH * WIDTH;
    localparam int              C_CW        = $clog2(C_FRAME_LEN);
    localparam logic [C_CW-1:0] C_CNT_LAST  = C_CW'(C_FRAME_LEN - 1);
    // DEPTH widened by one bit so the range check also works when DEPTH is a
    // power of two (every address is then legal)
    localparam logic [AW:0]     C_DEPTH_EXT = (AW + 1)'(DEPTH);

    // Storage and its next-state image
    logic [WIDTH-1:0] r_field     [DEPTH];
    logic [WIDTH-1:0] w_field_nxt [DEPTH];

    // Bit entering the bottom of each field on a shift
    logic [DEPTH-1:0] w_carry;

    logic             r_ssel_prev;
    logic             w_shift;
    logic             w_wr_in_range;
    logic             w_wr_ok;

    logic [C_CW-1:0]  r_cnt;
    logic             r_frame_done;
    logic             r_wr_drop;
    logic [WIDTH-1:0] r_rd_data;

    // True when the address selects an existing field
    function automatic logic addr_in_range(input logic [AW-1:0] addr);
        return ({1'b0, addr} < C_DEPTH_EXT);
    endfunction

    // Field contents for the read ports; non-existent fields read as zero
    function automatic logic [WIDTH-1:0] read_field(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] val;
        val = '0;
        if (addr_in_range(addr)) begin
            val = r_field[addr];
        end
        return val;
    endfunction

    // One shift per rising edge of ssel; a shift always beats a write
    assign w_shift       = ssel & ~r_ssel_prev;
    assign w_wr_in_range = addr_in_range(wr_addr);
    assign w_wr_ok       = wr_en & ~w_shift & w_wr_in_range;

    // Scan output comes straight from storage so it tracks each shift edge
    assign sout       = r_field[DEPTH-1][WIDTH-1];
    assign frame_done = r_frame_done;
    assign wr_drop    = r_wr_drop;
    assign rd_data    = r_rd_data;

    // Chain linkage: field 0 takes sin, every other field takes the MSB of
    // the field below it
    always_comb begin
        w_carry    = '0;
        w_carry[0] = sin;
        for (int i = 1; i < DEPTH; i++) begin
            w_carry[i] = r_field[i-1][WIDTH-1];
        end
    end

    // Next value of every field: whole-chain shift, else a single-field write
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_field_nxt[i] = r_field[i];
            if (w_shift) begin
                w_field_nxt[i] = {r_field[i][WIDTH-2:0], w_carry[i]};
            end else if (w_wr_ok && (wr_addr == AW'(i))) begin
                w_field_nxt[i] = wr_data;
            end
        end
    end

    // Field storage; reset discards any partially shifted frame
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_field[i] <= '0;
            end
        end else begin
            r_field <= w_field_nxt;
        end
    end

    // ssel history for edge detection; reset clears it so a high ssel in
    // the first cycle after reset still counts as an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ssel_prev <= 1'b0;
        end else begin
            r_ssel_prev <= ssel;
        end
    end

    // Frame bit counter with a one-cycle pulse on wrap; sclr restarts the
    // frame and suppresses a pulse on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else if (sclr) begin
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else if (w_shift) begin
            if (r_cnt == C_CNT_LAST) begin
                r_cnt        <= '0;
                r_frame_done <= 1'b1;
            end else begin
                r_cnt        <= r_cnt + 1'b1;
                r_frame_done <= 1'b0;
            end
        end else begin
            r_frame_done <= 1'b0;
        end
    end

    // Report a discarded write request one cycle after it was presented
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= wr_en & (w_shift | ~w_wr_in_range);
        end
    end

    // Registered read: samples pre-edge storage, so a colliding write or
    // shift shows up one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= read_field(rd_addr);
        end
    end

`ifdef PATBUF_RD2_EN
    logic [WIDTH-1:0] r_rd2_data;

    assign rd2_data = r_rd2_data;

    // Second registered read port, independent of the first
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd2_data <= '0;
        end else begin
            r_rd2_data <= read_field(rd2_addr);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pattern_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_bank
// Description : Scoreboard bench for pattern_bank. Stimulus steps push the
//               expected outputs (from a small behavioural model plus
//               hand-computed values) tagged with the cycle they are due; a
//               monitor on the falling edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_bank;

    localparam int DEPTH = 22;
    localparam int WIDTH = 8;
    localparam int AW    = 5;
    localparam int FLEN  = DEPTH * WIDTH;

    // Scoreboard entry kinds
    localparam int K_RD    = 0;
    localparam int K_SOUT  = 1;
    localparam int K_DROP  = 2;
    localparam int K_DONE  = 3;
    localparam int K_RD2   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ssel;
    logic             sin;
    logic             sout;
    logic             sclr;
    logic             frame_done;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             wr_drop;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
`ifdef PATBUF_RD2_EN
    logic [AW-1:0]    rd2_addr;
    logic [WIDTH-1:0] rd2_data;
`endif

    always #5 clk = ~clk;

    pattern_bank #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .ssel       (ssel),
        .sin        (sin),
        .sout       (sout),
        .sclr       (sclr),
        .frame_done (frame_done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_drop    (wr_drop),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
`ifdef PATBUF_RD2_EN
        ,
        .rd2_addr   (rd2_addr),
        .rd2_data   (rd2_data)
`endif
    );

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    // Behavioural model state
    logic [7:0] mf [DEPTH];
    int         mcnt;
    logic       mprev;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_RD:    return "rd_data";
            K_SOUT:  return "sout";
            K_DROP:  return "wr_drop";
            K_DONE:  return "frame_done";
            default: return "rd2_data";
        endcase
    endfunction

    function automatic logic [7:0] actual(input int k);
        case (k)
            K_RD:    return rd_data;
            K_SOUT:  return {7'b0, sout};
            K_DROP:  return {7'b0, wr_drop};
            K_DONE:  return {7'b0, frame_done};
`ifdef PATBUF_RD2_EN
            K_RD2:   return rd2_data;
`endif
            default: return 8'h00;
        endcase
    endfunction

    // Monitor: compare every entry due at this cycle
    always @(negedge clk) begin
        logic [7:0] act;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                act = actual(q[i].kind);
                total++;
                if ((q[i].cyc < cyc) || (act !== q[i].val)) begin
                    bad++;
                    $display("FAIL %s cyc=%0d due=%0d actual=%h required=%h",
                             kname(q[i].kind), cyc, q[i].cyc, act, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    task automatic push(input int kind, input logic [7:0] val, input int off);
        exp_t e;
        e.cyc  = cyc + off;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask

    // One clock of stimulus; model computes every output for the next cycle
    task automatic step(input logic r, input logic s, input logic d,
                        input logic c, input logic we,
                        input logic [AW-1:0] wa, input logic [7:0] wd,
                        input logic [AW-1:0] ra);
        logic [7:0] old [DEPTH];
        logic       sh;
        logic [7:0] rdv;
        logic       drop;
        logic       done;
        rst = r; ssel = s; sin = d; sclr = c;
        wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
`ifdef PATBUF_RD2_EN
        rd2_addr = ra;
`endif
        old  = mf;
        rdv  = 8'h00;
        drop = 1'b0;
        done = 1'b0;
        if (r) begin
            for (int i = 0; i < DEPTH; i++) mf[i] = 8'h00;
            mcnt  = 0;
            mprev = 1'b0;
        end else begin
            sh   = s & ~mprev;
            rdv  = (int'(ra) < DEPTH) ? old[ra] : 8'h00;
            drop = we & (sh | (int'(wa) >= DEPTH));
            if (c) begin
                mcnt = 0;
            end else if (sh) begin
                if (mcnt == FLEN - 1) begin
                    mcnt = 0;
                    done = 1'b1;
                end else begin
                    mcnt++;
                end
            end
            if (sh) begin
                mf[0] = {old[0][6:0], d};
                for (int i = 1; i < DEPTH; i++) mf[i] = {old[i][6:0], old[i-1][7]};
            end else if (we && (int'(wa) < DEPTH)) begin
                mf[wa] = wd;
            end
            mprev = s;
        end
        push(K_RD,   rdv, 1);
        push(K_SOUT, {7'b0, mf[DEPTH-1][7]}, 1);
        push(K_DROP, {7'b0, drop}, 1);
        push(K_DONE, {7'b0, done}, 1);
`ifdef PATBUF_RD2_EN
        push(K_RD2,  rdv, 1);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic idle_rd(input logic [AW-1:0] ra);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00, ra);
    endtask

    task automatic wr(input logic [AW-1:0] wa, input logic [7:0] wd, input logic [AW-1:0] ra);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, wa, wd, ra);
    endtask

    // One shift edge (ssel rise) followed by ssel low
    task automatic shift_bit(input logic d, input logic c);
        step(1'b0, 1'b1, d, c, 1'b0, '0, 8'h00, '0);
        step(1'b0, 1'b0, d, 1'b0, 1'b0, '0, 8'h00, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        logic [7:0] seq;
        int         idx;
        rst = 1'b1; ssel = 1'b0; sin = 1'b0; sclr = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = 8'h00; rd_addr = '0;
`ifdef PATBUF_RD2_EN
        rd2_addr = '0;
`endif
        for (int i = 0; i < DEPTH; i++) mf[i] = 8'h00;
        mcnt = 0; mprev = 1'b0;
        @(posedge clk);
        #1;

        // 1: reset, then sweep every field
        push(K_SOUT, 8'h00, 1);
        push(K_DONE, 8'h00, 1);
        push(K_DROP, 8'h00, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00, '0);
        for (int a = 0; a < DEPTH; a++) begin
            push(K_RD, 8'h00, 1);
            idle_rd(AW'(a));
        end

        // 2: field writes, old data on a same-cycle read
        push(K_RD, 8'h00, 1);
        wr(5'd5, 8'hA5, 5'd5);
        wr(5'd21, 8'h3C, 5'd0);
        push(K_RD, 8'hA5, 1);
        idle_rd(5'd5);
        push(K_RD, 8'h3C, 1);
        idle_rd(5'd21);

        // 3: full serial frame; byte j (MSB first) = 0x10 + j
        for (int j = 0; j < DEPTH; j++) begin
            b = 8'h10 + 8'(j);
            for (int k = 7; k >= 0; k--) begin
                idx = j * 8 + (7 - k) + 1;
                if (idx == FLEN) push(K_DONE, 8'h01, 1);
                shift_bit(b[k], 1'b0);
            end
        end
        push(K_RD, 8'h25, 1);
        idle_rd(5'd0);
        push(K_RD, 8'h10, 1);
        idle_rd(5'd21);
        // ssel held high gives a single shift of sin=1
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 8'h00, '0);
        idle_rd(5'd0);
        push(K_RD, 8'h4B, 1);
        idle_rd(5'd0);

        // 4: readback of a preloaded field through sout
        wr(5'd21, 8'h81, 5'd0);
        seq = 8'h81;
        for (int k = 7; k >= 0; k--) begin
            push(K_SOUT, {7'b0, seq[k]}, 0);
            shift_bit(1'b0, 1'b0);
        end
        push(K_RD, 8'h00, 1);
        idle_rd(5'd0);

        // 5: write colliding with a shift, and an out-of-range write
        push(K_DROP, 8'h01, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 8'hFF, 5'd3);
        idle_rd(5'd3);
        push(K_RD, 8'h8C, 1);
        idle_rd(5'd3);
        push(K_DROP, 8'h01, 1);
        wr(5'd25, 8'h77, 5'd0);
        for (int a = 0; a < DEPTH; a++) idle_rd(AW'(a));

        // 6: reset mid-frame, then a full frame; then sclr mid-frame
        for (int k = 0; k < 100; k++) shift_bit(k[0], 1'b0);
        push(K_SOUT, 8'h00, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00, '0);
        push(K_RD, 8'h00, 1);
        idle_rd(5'd21);
        for (int k = 1; k <= FLEN; k++) begin
            if (k == FLEN) push(K_DONE, 8'h01, 1);
            shift_bit(k[1], 1'b0);
        end
        for (int k = 1; k <= 50; k++) begin
            if (k == 50) push(K_DONE, 8'h00, 1);
            shift_bit(k[0], k == 50);
        end
        for (int k = 1; k <= FLEN; k++) begin
            if (k == FLEN) push(K_DONE, 8'h01, 1);
            shift_bit(k[2], 1'b0);
        end

        // Both read ports on the same field
        wr(5'd5, 8'hA5, 5'd0);
        push(K_RD, 8'hA5, 1);
`ifdef PATBUF_RD2_EN
        push(K_RD2, 8'hA5, 1);
`endif
        idle_rd(5'd5);

        repeat (3) @(posedge clk);
        #6;
        if (q.size() != 0) begin
            bad += q.size();
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pattern_bank.md
Name: pattern_bank

Overview:
- Parametrised next-generation pattern store for the PAT processor. Holds DEPTH fields of WIDTH bits.
- Two access paths:
  - a bit-serial scan chain (sin to sout) for external load and readback;
  - a binary-addressed field write port and a registered field read port for the PAT core.
- Additions over the previous buffer:
  - binary addressing;
  - synchronous reset;
  - a frame bit counter with a frame-complete pulse;
  - explicit shift/write arbitration with drop reporting;
  - a pipelined read.

Parameters:
- DEPTH, 22, number of fields (≥2).
- WIDTH, 8, bits per field (≥2).
- AW, $clog2(DEPTH), field address width (derived localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- ssel  in  1  serial shift strobe; one shift per 0→1 transition
- sin  in  1  serial data in, enters field 0 bit 0
- sout  out  1  serial data out = field[DEPTH-1] bit WIDTH-1 (combinational from storage)
- sclr  in  1  synchronous clear of frame bit counter
- frame_done  out  1  one-cycle pulse after DEPTH*WIDTH shifts
- wr_en  in  1  field write request
- wr_addr  in  AW  field write address
- wr_data  in  WIDTH  field write data
- wr_drop  out  1  one-cycle pulse: the write request of the previous cycle was discarded
- rd_addr  in  AW  field read address
- rd_data  out  WIDTH  registered read data

Behaviour:
- Reset (rst=1 at clk edge) dominates all other inputs. After that edge:
  - all fields = 0, rd_data = 0;
  - frame counter = 0, ssel_prev = 0;
  - frame_done = 0, wr_drop = 0;
  - sout therefore = 0.
- Edge detect: ssel_prev <= ssel every cycle. shift = ssel & ~ssel_prev.
  - ssel held high gives exactly one shift.
  - ssel high in the first cycle after reset counts as an edge.
- Shift (shift=1):
  - field[0] <= {field[0][WIDTH-2:0], sin};
  - field[i] <= {field[i][WIDTH-2:0], field[i-1][WIDTH-1]} for i=1..DEPTH-1;
  - all fields update on the same edge.
- Frame counter, range 0..DEPTH*WIDTH-1:
  - increments on each shift;
  - on a shift at value DEPTH*WIDTH-1 it wraps to 0 and frame_done=1 in the following cycle only;
  - sclr=1 forces counter 0 and suppresses frame_done for that edge, even with a coincident shift (that shift still moves data).
- Write: accepted when wr_en=1, shift=0 and wr_addr<DEPTH; field[wr_addr] <= wr_data on that edge.
- Write discarded, with wr_drop=1 next cycle, when wr_en=1 and either:
  - shift=1 (shift wins; no field is written), or
  - wr_addr≥DEPTH.
- wr_drop=0 whenever wr_en=0.
- Read, latency 1: rd_data <= (rd_addr<DEPTH) ? field[rd_addr] : 0 every non-reset cycle.
  - Same-cycle write or shift to the read field: rd_data shows the pre-edge (old) value. New value visible one cycle later.
- sout follows storage immediately after each shift edge. No extra register.
- Reset mid-frame: partially shifted data is lost (zeroed) and the counter restarts at 0.

Optional Feature:
- Macro PATBUF_RD2_EN.
- Defined:
  - adds ports rd2_addr (in, AW) and rd2_data (out, WIDTH);
  - rd2 is an independent second read port with rules identical to rd_addr/rd_data (latency 1, out-of-range → 0, old-data-on-collision, reset 0);
  - both ports may address the same field in the same cycle.
- Undefined: the ports do not exist and there is no extra logic.

Test Plan:
1. Reset then rd_addr=0..21 sweep → rd_data=0x00 for every field, one cycle after each address; sout=0; frame_done and wr_drop stay 0.
2. Write field 5 = 0xA5 and field 21 = 0x3C, then read 5 and 21 → 0xA5 and 0x3C one cycle after the address. Same-cycle read of 5 during the write → old value 0x00.
3. Serial frame: toggle ssel 176 times with sin streaming 176 bits → frame_done pulses once, on the cycle after the 176th edge.
   - Field 0 holds the last 8 bits shifted; field 21 holds the first 8 bits.
   - Holding ssel high for 10 cycles gives 1 shift only.
4. Readback: preload field 21 = 0x81 by write, then 8 shifts with sin=0 → sout sequence 1,0,0,0,0,0,0,1 sampled before each shift. Field 0 = 0x00 afterwards.
5. Conflict: wr_en=1, wr_addr=3, wr_data=0xFF coincident with a shift edge → field 3 shows the shifted value, not 0xFF; wr_drop=1 next cycle. wr_addr=25 write → wr_drop=1 and no field changes.
6. Reset and sclr mid-frame: after 100 shifts, assert rst → all fields 0; 176 further shifts → frame_done exactly at shift 176. Repeat with sclr at shift 50 → frame_done 176 shifts after the sclr cycle.
   - With PATBUF_RD2_EN: rd_addr=rd2_addr=5 → both return 0xA5.
